sw_alloc_rr7: RTL and testbench
===============================

// Module: sw_alloc_rr7
//
// PURPOSE
// Switch allocator for the 7-port router. Each input presents one target output port per
// cycle. Per output, picks one requesting input by round-robin, gated by a credit counter
// tracking free slots in that output's downstream buffer. Drives crossbar select and
// input-FIFO pop; sits between input buffers and crossbar.
//
// PARAMETERS
// N      7   number of input and output ports; also the number of requesters per output
// DEPTH  4   downstream buffer slots per output, i.e. initial credits
// PW     3   target/select width; must hold 0..N
//
// PORTS
// clk      in   1      clock, rising edge
// rst      in   1      reset, asynchronous, active-low
// req      in   N      req[i]=1: input i holds a flit to forward
// targ     in   PW*N   targ[PW*i +: PW] = target output of input i, 1..N; 0 = none
// cred_in  in   N      cred_in[o]=1: downstream of output o freed one slot this cycle
// gnt      out  N      gnt[i]=1: input i won; pop its FIFO this cycle
// out_vld  out  N      out_vld[o]=1: output o carries a flit this cycle
// out_sel  out  PW*N   out_sel[PW*o +: PW] = winning input index+1; 0 when idle
// cred_err out  1      sticky; set on a credit return while the counter is already DEPTH
//
// BEHAVIOUR
// - Reset (async, rst=0): gnt=0, out_vld=0, out_sel=0, cred_err=0.
//   Every credit counter is DEPTH. Every RR pointer is 0.
// - Ports are numbered 1..N on targ/out_sel and 0..N-1 on bit vectors.
//   Output o (bit o) matches targ value o+1.
// - Request vector of output o, bit i = req[i] && targ_i==o+1.
//   targ=0 or targ>N: ignored, never granted.
// - Output o is eligible when its registered credit count is >0.
//   cred_in of the same cycle does not make o eligible until the next cycle.
// - Arbitration: among requesters of eligible output o, winner = first set bit at or after
//   ptr[o], searching upward with wrap N-1 -> 0.
// - Latency: 1 cycle. Requests sampled at edge k; gnt/out_vld/out_sel valid after edge k
//   and held for exactly one cycle.
// - Requesters must hold req/targ until gnt is seen; gnt is a single-cycle pulse.
// - Each input names one target, so at most one gnt bit per input.
//   Up to N outputs may grant in one cycle.
// - On a grant to input i at output o: ptr[o] <= (i+1) mod N.
//   With no grant at o, ptr[o] holds.
// - Credit counter, width clog2(DEPTH+1):
//   - grant only: count-1
//   - cred_in only: count+1, saturating at DEPTH
//   - grant and cred_in together: unchanged
//   - cred_in at count==DEPTH with no grant: count stays DEPTH, cred_err <= 1
//   - count never goes below 0 (a grant needs count>0)
// - cred_err clears only on reset.
// - Reset mid-operation clears all state immediately. Any gnt pulse in flight is dropped.
//   Upstream must also discard any pop it has not yet completed.
//
// STRUCTURE
// - noc_pkg (shared): N, DEPTH, PW, port encoding (0=NONE, 1..N), CNT_W=clog2(DEPTH+1).
// - Sub-module rr_arb (N-wide): inputs req vector, ptr, en.
//   Outputs one-hot grant and its index. Instantiated N times, one per output.
// - Top level holds: request-matrix decode, N credit counters, registered
//   gnt/out_vld/out_sel, cred_err.
//
// TESTING
// 1. Reset: hold rst=0 with random req/targ -> all outputs 0; after release, counters read DEPTH=4.
// 2. Single: req[2]=1, targ2=5 -> next cycle gnt=7'b0000100, out_vld[4]=1, out_sel[4]=3.
// 3. Round-robin: inputs 0,3,6 hold targ=2 -> out_sel[1] sequence 1,4,7,1.
//    One grant per cycle, no starvation.
// 4. Credits: input 0 streams to output 1 with no cred_in -> exactly 4 grants, then stall.
//    One cred_in[0] -> exactly one more grant.
// 5. Simultaneous: count=2, grant and cred_in[o] in the same cycle -> count stays 2;
//    cred_in when count=4 with no grant -> cred_err=1 and stays set.
// 6. Parallel: all 7 inputs target distinct outputs -> gnt=7'h7F in one cycle.
//    Assert rst mid-stream -> all outputs 0 asynchronously, before the next edge.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared router constants: port count, downstream buffer depth and the 1-based
// port encoding used on target/select buses (0 means no port).
package noc_pkg;

   localparam int unsigned N     = 7;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned PW    = 3;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(N);

   localparam logic [PW-1:0] PORT_NONE = '0;

   // Bit-vector index (0..N-1) to port number (1..N).
   function automatic logic [PW-1:0] to_port(input logic [PTR_W-1:0] idx);
      return PW'(idx) + PW'(1);
   endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin picker for one output: first requester at or above the pointer,
// wrapping from N-1 back to 0. Purely combinational.
module rr_arb
   import noc_pkg::*;
(
   input  logic [N-1:0]     i_req,
   input  logic [PTR_W-1:0] i_ptr,
   input  logic             i_en,
   output logic [N-1:0]     o_gnt,
   output logic [PTR_W-1:0] o_idx,
   output logic             o_vld
);

   int unsigned w_j;

   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_vld = 1'b0;
      w_j   = 0;
      if (i_en) begin
         for (int unsigned k = 0; k < N; k++) begin
            w_j = 32'(i_ptr) + k;
            if (w_j >= N) w_j = w_j - N;
            if (!o_vld && i_req[w_j]) begin
               o_vld      = 1'b1;
               o_gnt[w_j] = 1'b1;
               o_idx      = PTR_W'(w_j);
            end
         end
      end
   end

endmodule

// File: rtl/sw_alloc_rr7.sv
// Switch allocator: per-output round-robin arbitration gated by downstream credits,
// with registered grant, crossbar select and a sticky credit-overflow flag.
module sw_alloc_rr7
   import noc_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    i_req,
   input  logic [PW*N-1:0] i_targ,
   input  logic [N-1:0]    i_cred_in,
   output logic [N-1:0]    o_gnt,
   output logic [N-1:0]    o_out_vld,
   output logic [PW*N-1:0] o_out_sel,
   output logic            o_cred_err
);

   logic [N-1:0][N-1:0]     w_req_mat;
   logic [N-1:0][N-1:0]     w_arb_gnt;
   logic [N-1:0][PTR_W-1:0] w_idx;
   logic [N-1:0]            w_win;
   logic [N-1:0]            w_en;

   logic [N-1:0][PTR_W-1:0] r_ptr, w_ptr_d;
   logic [N-1:0][CNT_W-1:0] r_cnt, w_cnt_d;
   logic [N-1:0]            r_gnt, w_gnt_d;
   logic [N-1:0]            r_vld, w_vld_d;
   logic [PW*N-1:0]         r_sel, w_sel_d;
   logic                    r_err, w_err_d;

   // Row o collects inputs whose target is output o; targ 0 never matches.
   always_comb begin
      w_req_mat = '0;
      for (int unsigned o = 0; o < N; o++) begin
         w_en[o] = (r_cnt[o] != '0);
         for (int unsigned i = 0; i < N; i++) begin
            w_req_mat[o][i] = i_req[i] && (i_targ[PW*i +: PW] == to_port(PTR_W'(o)));
         end
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_arb
      rr_arb u_arb (
         .i_req (w_req_mat[g]),
         .i_ptr (r_ptr[g]),
         .i_en  (w_en[g]),
         .o_gnt (w_arb_gnt[g]),
         .o_idx (w_idx[g]),
         .o_vld (w_win[g])
      );
   end

   always_comb begin
      w_gnt_d = '0;
      w_vld_d = '0;
      w_sel_d = '0;
      w_ptr_d = r_ptr;
      w_cnt_d = r_cnt;
      w_err_d = r_err;
      for (int unsigned o = 0; o < N; o++) begin
         w_gnt_d    = w_gnt_d | w_arb_gnt[o];
         w_vld_d[o] = w_win[o];
         if (w_win[o]) begin
            w_sel_d[PW*o +: PW] = to_port(w_idx[o]);
            w_ptr_d[o]          = (w_idx[o] == PTR_W'(N - 1)) ? '0 : w_idx[o] + PTR_W'(1);
         end
         // A grant and a returned credit in the same cycle cancel out.
         if (w_win[o] && !i_cred_in[o]) begin
            w_cnt_d[o] = r_cnt[o] - CNT_W'(1);
         end else if (!w_win[o] && i_cred_in[o]) begin
            if (r_cnt[o] == CNT_W'(DEPTH)) w_err_d = 1'b1;
            else                           w_cnt_d[o] = r_cnt[o] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr <= '0;
         r_cnt <= {N{CNT_W'(DEPTH)}};
         r_gnt <= '0;
         r_vld <= '0;
         r_sel <= {N{PORT_NONE}};
         r_err <= 1'b0;
      end else begin
         r_ptr <= w_ptr_d;
         r_cnt <= w_cnt_d;
         r_gnt <= w_gnt_d;
         r_vld <= w_vld_d;
         r_sel <= w_sel_d;
         r_err <= w_err_d;
      end
   end

   assign o_gnt      = r_gnt;
   assign o_out_vld  = r_vld;
   assign o_out_sel  = r_sel;
   assign o_cred_err = r_err;

endmodule

// File: tb/tb_sw_alloc_rr7.sv
// Bench for sw_alloc_rr7: directed scenarios plus a random phase, all checked
// against a cycle-level reference model of the allocation rules.
module tb_sw_alloc_rr7;

   logic        clk;
   logic        rst;
   logic [6:0]  req;
   logic [20:0] targ;
   logic [6:0]  cred;
   logic [6:0]  gnt;
   logic [6:0]  vld;
   logic [20:0] sel;
   logic        err;

   int errors = 0;
   int checks = 0;

   int m_cnt[7];
   int m_ptr[7];
   bit m_err;
   logic [6:0] last_gnt;

   sw_alloc_rr7 dut (
      .clk        (clk),
      .rst        (rst),
      .i_req      (req),
      .i_targ     (targ),
      .i_cred_in  (cred),
      .o_gnt      (gnt),
      .o_out_vld  (vld),
      .o_out_sel  (sel),
      .o_cred_err (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int o = 0; o < 7; o++) begin
         m_cnt[o] = 4;
         m_ptr[o] = 0;
      end
      m_err    = 1'b0;
      last_gnt = '0;
   endtask

   // Predict from the current inputs, clock once, then compare all outputs.
   task automatic step(input string tag);
      logic [6:0]  eg, ev;
      logic [20:0] es;
      int nc[7];
      int np[7];
      bit ne;
      int win, i;
      eg = '0; ev = '0; es = '0; ne = m_err;
      for (int o = 0; o < 7; o++) begin
         nc[o] = m_cnt[o];
         np[o] = m_ptr[o];
         win   = -1;
         if (m_cnt[o] > 0) begin
            for (int k = 0; k < 7; k++) begin
               i = (m_ptr[o] + k) % 7;
               if (win < 0 && req[i] && int'(targ[3*i +: 3]) == o + 1) win = i;
            end
         end
         if (win >= 0) begin
            eg[win]       = 1'b1;
            ev[o]         = 1'b1;
            es[3*o +: 3]  = 3'(win + 1);
            np[o]         = (win + 1) % 7;
         end
         if (win >= 0 && !cred[o]) nc[o] = nc[o] - 1;
         else if (win < 0 && cred[o]) begin
            if (m_cnt[o] == 4) ne = 1'b1;
            else nc[o] = nc[o] + 1;
         end
      end
      @(posedge clk);
      #1;
      if (!rst) begin
         model_reset();
         eg = '0; ev = '0; es = '0; ne = 1'b0;
      end else begin
         for (int o = 0; o < 7; o++) begin
            m_cnt[o] = nc[o];
            m_ptr[o] = np[o];
         end
         m_err    = ne;
         last_gnt = eg;
      end
      chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
      chk({tag, ".vld"}, 32'(vld), 32'(ev));
      chk({tag, ".sel"}, 32'(sel), 32'(es));
      chk({tag, ".err"}, 32'(err), 32'(ne));
   endtask

   task automatic set_targ(input int i, input int t);
      targ[3*i +: 3] = 3'(t);
   endtask

   int cnt_g;
   int rr_seq[4] = '{1, 4, 7, 1};

   initial begin
      rst  = 1'b0;
      req  = '0;
      targ = '0;
      cred = '0;
      model_reset();

      // Reset held with random activity: outputs stay zero.
      for (int c = 0; c < 5; c++) begin
         req  = 7'($urandom);
         targ = 21'($urandom);
         cred = 7'($urandom);
         step("reset_hold");
      end
      rst  = 1'b1;
      req  = '0;
      cred = '0;
      step("idle");

      // Single request: input 2 to port 5.
      req[2] = 1'b1;
      set_targ(2, 5);
      step("single");
      chk("single.gnt_const", 32'(gnt), 32'h04);
      chk("single.vld4", 32'(vld[4]), 32'd1);
      chk("single.sel4", 32'(sel[14:12]), 32'd3);
      req = '0;
      step("single_after");

      // Round-robin on output 1 among inputs 0, 3, 6.
      req = 7'b1001001;
      set_targ(0, 2); set_targ(3, 2); set_targ(6, 2);
      for (int k = 0; k < 4; k++) begin
         step("rr");
         chk("rr.sel1", 32'(sel[5:3]), 32'(rr_seq[k]));
      end
      req = '0;
      cred[1] = 1'b1;
      for (int k = 0; k < 4; k++) step("rr_refill");
      cred = '0;

      // Credits: stream input 0 to output 1 with no returns.
      req[0] = 1'b1;
      set_targ(0, 2);
      cnt_g = 0;
      for (int k = 0; k < 6; k++) begin
         step("cred_stream");
         cnt_g += int'(gnt[0]);
      end
      chk("cred.four_grants", 32'(cnt_g), 32'd4);
      cred[1] = 1'b1;
      step("cred_return");
      cred = '0;
      cnt_g = 0;
      for (int k = 0; k < 3; k++) begin
         step("cred_one_more");
         cnt_g += int'(gnt[0]);
      end
      chk("cred.one_more", 32'(cnt_g), 32'd1);

      // Simultaneous grant and return at count 2.
      req = '0;
      cred[1] = 1'b1;
      step("sim_fill"); step("sim_fill");
      req[0] = 1'b1;
      step("sim_both");
      chk("sim.granted", 32'(gnt[0]), 32'd1);
      cred = '0;
      cnt_g = 0;
      for (int k = 0; k < 4; k++) begin
         step("sim_drain");
         cnt_g += int'(gnt[0]);
      end
      chk("sim.count_stays_2", 32'(cnt_g), 32'd2);
      req = '0;
      cred[1] = 1'b1;
      for (int k = 0; k < 4; k++) step("err_fill");
      chk("err.not_yet", 32'(err), 32'd0);
      step("err_overflow");
      chk("err.set", 32'(err), 32'd1);
      cred = '0;
      step("err_hold"); step("err_hold");
      chk("err.sticky", 32'(err), 32'd1);

      // Random traffic; requests change only when granted or idle.
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < 7; i++) begin
            if (last_gnt[i] || !req[i]) begin
               req[i] = ($urandom_range(0, 2) != 0);
               set_targ(i, $urandom_range(0, 7));
            end
         end
         for (int o = 0; o < 7; o++) cred[o] = (m_cnt[o] < 4) && ($urandom_range(0, 3) == 0);
         step("rand");
      end

      // Reset clears the sticky flag, then all inputs target distinct outputs.
      req  = '0;
      cred = '0;
      rst  = 1'b0;
      step("rst_again");
      chk("rst.err_clear", 32'(err), 32'd0);
      rst = 1'b1;
      for (int i = 0; i < 7; i++) set_targ(i, ((i + 3) % 7) + 1);
      req = 7'h7F;
      step("parallel");
      chk("parallel.gnt_all", 32'(gnt), 32'h7F);
      step("parallel2");
      #2;
      rst = 1'b0;
      #1;
      chk("async.gnt", 32'(gnt), 32'd0);
      chk("async.vld", 32'(vld), 32'd0);
      chk("async.sel", 32'(sel), 32'd0);
      chk("async.err", 32'(err), 32'd0);
      model_reset();
      step("async_hold");
      rst = 1'b1;
      req = '0;
      step("final_idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
